// File: rtl/lsu_ctrl.sv
// Load/store control stage feeding the data memory port. It holds one access for
// LATENCY cycles, writes a store exactly once, and returns extended load data to WBU.
module lsu_ctrl #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        mem_ena,
    output logic        mem_wen,
    output logic [3:0]  mem_mask,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q;
    logic [2:0]  f3_q;
    logic [63:0] addr_q, wdata_q;
    logic [63:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;

    logic        accept, illegal, misaligned, in_access, last_beat;
    logic [5:0]  lane_sh;
    logic [63:0] rd_sh, load_val;

    assign accept  = req_valid && (state_q == IDLE);
    assign illegal = (req_funct3 == 3'b111) || (req_wen && req_funct3[2]);

    always_comb begin
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // mem_rdata arrives unshifted; bring the addressed lane down to bit 0 first.
    assign lane_sh = {addr_q[2:0], 3'b000};
    assign rd_sh   = mem_rdata >> lane_sh;

    always_comb begin
        case (f3_q[1:0])
            2'b00:   load_val = f3_q[2] ? {56'd0, rd_sh[7:0]}  : {{56{rd_sh[7]}}, rd_sh[7:0]};
            2'b01:   load_val = f3_q[2] ? {48'd0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
            2'b10:   load_val = f3_q[2] ? {32'd0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
            default: load_val = rd_sh;
        endcase
    end

    assign in_access = (state_q == ACCESS);
    assign last_beat = in_access && (cnt_q == 4'd0);

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign mem_ena    = in_access;
    // Write strobe only on the final beat so a multi-cycle store lands once.
    assign mem_wen    = last_beat && wen_q;
    assign mem_addr   = in_access ? addr_q : 64'd0;
    assign mem_wdata  = in_access ? (wdata_q << lane_sh) : 64'd0;

    always_comb begin
        mem_mask = 4'b0000;
        if (in_access) begin
            case (f3_q[1:0])
                2'b00:   mem_mask = 4'b1000;
                2'b01:   mem_mask = 4'b0100;
                2'b10:   mem_mask = 4'b0010;
                default: mem_mask = 4'b0001;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal || misaligned) begin
                        state_d     = RESP;
                        resp_err_d  = 1'b1;
                        resp_data_d = 64'd0;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    resp_err_d  = 1'b0;
                    resp_data_d = wen_q ? 64'd0 : load_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d     = IDLE;
                    resp_data_d = 64'd0;
                    resp_err_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            resp_data_q <= 64'd0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
        end else if (accept) begin
            wen_q   <= req_wen;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: three instances (LATENCY 1/3/4) share a byte-array memory;
// directed vectors, stall/reset sequences, then random traffic against a byte-level model.
module tb_lsu_ctrl;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [NI];
    logic        resp_ready [NI];
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata, mem_rdata;
    logic        req_ready [NI], mem_ena [NI], mem_wen [NI], resp_valid [NI], resp_err [NI];
    logic [3:0]  mem_mask [NI];
    logic [63:0] mem_addr [NI], mem_wdata [NI], resp_data [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        lsu_ctrl #(.LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_wen(req_wen), .req_funct3(req_funct3),
            .req_addr(req_addr), .req_wdata(req_wdata),
            .mem_ena(mem_ena[g]), .mem_wen(mem_wen[g]), .mem_mask(mem_mask[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
            .resp_data(resp_data[g]), .resp_err(resp_err[g])
        );
    end

    function automatic int lat_of(input int k);
        return k == 0 ? 1 : (k == 1 ? 3 : 4);
    endfunction

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 2));
    endfunction

    function automatic int mask_bytes(input logic [3:0] m);
        if (m[0]) return 8;
        if (m[1]) return 4;
        if (m[2]) return 2;
        if (m[3]) return 1;
        return 0;
    endfunction

    // Memory port model: 128 bytes, doubleword read, masked lane write.
    int          sel = 0;
    logic        rd_force = 1'b0;
    logic [63:0] rd_val = '0;
    logic        mem_init = 1'b0;
    logic [7:0]  pmem [128];
    logic [7:0]  rmem [128];

    always_comb begin
        mem_rdata = '0;
        if (rd_force) mem_rdata = rd_val;
        else for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = pmem[{mem_addr[sel][6:3], 3'(i)}];
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) pmem[i] <= init_byte(i);
        end else if (mem_ena[sel] && mem_wen[sel]) begin
            for (int i = 0; i < 8; i++)
                if (i >= int'(mem_addr[sel][2:0]) && i < int'(mem_addr[sel][2:0]) + mask_bytes(mem_mask[sel]))
                    pmem[{mem_addr[sel][6:3], 3'(i)}] <= mem_wdata[sel][8*i +: 8];
        end
    end

    // Reference model in terms of request semantics, byte by byte.
    function automatic logic ref_err(input logic wen, input logic [2:0] f3, input logic [63:0] a);
        int sz = 1 << f3[1:0];
        return (f3 == 3'b111) || (wen && f3[2]) || ((int'(a[2:0]) % sz) != 0);
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
        logic [63:0] v = '0;
        logic [63:0] ones = '1;
        int sz = 1 << f3[1:0];
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rmem[int'(a[6:0]) + i];
        if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (ones << (8 * sz));
        return v;
    endfunction

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag, input int k);
        chk({tag, "_req_ready"}, 64'(req_ready[k]), 64'd1);
        chk({tag, "_resp_valid"}, 64'(resp_valid[k]), 64'd0);
        chk({tag, "_mem_ena"}, 64'(mem_ena[k]), 64'd0);
        chk({tag, "_mem_wen"}, 64'(mem_wen[k]), 64'd0);
        chk({tag, "_mem_mask"}, 64'(mem_mask[k]), 64'd0);
        chk({tag, "_mem_addr"}, mem_addr[k], 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata[k], 64'd0);
        chk({tag, "_resp_data"}, resp_data[k], 64'd0);
        chk({tag, "_resp_err"}, 64'(resp_err[k]), 64'd0);
    endtask

    task automatic reinit();
        mem_init = 1'b1;
        for (int i = 0; i < 128; i++) rmem[i] = init_byte(i);
        @(posedge clk); #1;
        mem_init = 1'b0;
    endtask

    // One full transaction with resp_ready held high; reports what the port did.
    task automatic run_req(input int k, input logic wen, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd_in,
                           output logic [63:0] d, output logic e, output int lat,
                           output int ena_n, output int wen_n, output logic [3:0] mask,
                           output logic [63:0] wd);
        int cyc;
        sel = k;
        chk($sformatf("i%0d_ready_before", k), 64'(req_ready[k]), 64'd1);
        req_wen = wen; req_funct3 = f3; req_addr = a; req_wdata = wd_in;
        resp_ready[k] = 1'b1; req_valid[k] = 1'b1;
        ena_n = 0; wen_n = 0; mask = '0; wd = '0;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        cyc = 1;
        while (!resp_valid[k] && cyc < 40) begin
            if (mem_ena[k]) begin ena_n++; mask = mem_mask[k]; end
            if (mem_wen[k]) begin wen_n++; wd = mem_wdata[k]; end
            @(posedge clk); #1;
            cyc++;
        end
        lat = cyc; d = resp_data[k]; e = resp_err[k];
        @(posedge clk); #1;
        chk($sformatf("i%0d_idle_after", k), 64'(req_ready[k]), 64'd1);
    endtask

    typedef struct {
        int k; logic wen; logic [2:0] f3; logic [63:0] addr, wdata, rd; logic force_rd;
        logic [63:0] exp_d; logic exp_e; int exp_lat, exp_ena, exp_wen;
        logic [3:0] exp_mask; logic [63:0] exp_wd;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt [11];
        logic [63:0] d, wd, stall_d, exp;
        logic e;
        logic [3:0] mask;
        int lat, ena_n, wen_n, cyc, wen_seen, bad;

        vt[0]  = '{0, 1'b0, 3'd0, 64'h8000_0003, 64'h0, 64'h0000_0000_F000_0000, 1'b1,
                   64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 2, 1, 0, 4'b1000, 64'h0};
        vt[1]  = '{1, 1'b1, 3'd2, 64'h8000_0004, 64'h1234_5678, 64'h0, 1'b1,
                   64'h0, 1'b0, 4, 3, 1, 4'b0010, 64'h1234_5678_0000_0000};
        vt[2]  = '{1, 1'b0, 3'd6, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 1'b1,
                   64'h0000_0000_8765_4321, 1'b0, 4, 3, 0, 4'b0010, 64'h0};
        vt[3]  = '{1, 1'b0, 3'd2, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 1'b1,
                   64'hFFFF_FFFF_8765_4321, 1'b0, 4, 3, 0, 4'b0010, 64'h0};
        vt[4]  = '{0, 1'b0, 3'd3, 64'h8000_0004, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                   64'h0, 1'b1, 1, 0, 0, 4'b0000, 64'h0};
        vt[5]  = '{0, 1'b0, 3'd7, 64'h8000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                   64'h0, 1'b1, 1, 0, 0, 4'b0000, 64'h0};
        vt[6]  = '{2, 1'b1, 3'd4, 64'h8000_0000, 64'hAB, 64'h0, 1'b1,
                   64'h0, 1'b1, 1, 0, 0, 4'b0000, 64'h0};
        vt[7]  = '{2, 1'b0, 3'd1, 64'h8000_0005, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                   64'h0, 1'b1, 1, 0, 0, 4'b0000, 64'h0};
        vt[8]  = '{2, 1'b0, 3'd4, 64'h8000_0001, 64'h0, 64'hAAAA_AAAA_AAAA_80FF, 1'b1,
                   64'h0000_0000_0000_0080, 1'b0, 5, 4, 0, 4'b1000, 64'h0};
        vt[9]  = '{0, 1'b0, 3'd1, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, 1'b1,
                   64'hFFFF_FFFF_FFFF_8001, 1'b0, 2, 1, 0, 4'b0100, 64'h0};
        vt[10] = '{2, 1'b1, 3'd3, 64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b1,
                   64'h0, 1'b0, 5, 4, 1, 4'b0001, 64'hDEAD_BEEF_CAFE_F00D};

        rst_n = 1'b0; req_wen = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int k = 0; k < NI; k++) begin req_valid[k] = 1'b0; resp_ready[k] = 1'b1; end
        mem_init = 1'b1;
        for (int i = 0; i < 128; i++) rmem[i] = init_byte(i);
        #2;
        for (int k = 0; k < NI; k++) chk_reset($sformatf("rst%0d", k), k);
        @(posedge clk); @(posedge clk); #1;
        mem_init = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with a forced read doubleword
        for (int i = 0; i < 11; i++) begin
            rd_force = vt[i].force_rd; rd_val = vt[i].rd;
            run_req(vt[i].k, vt[i].wen, vt[i].f3, vt[i].addr, vt[i].wdata, d, e, lat, ena_n, wen_n, mask, wd);
            chk($sformatf("v%0d_data", i), d, vt[i].exp_d);
            chk($sformatf("v%0d_err", i), 64'(e), 64'(vt[i].exp_e));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
            chk($sformatf("v%0d_ena_cycles", i), 64'(ena_n), 64'(vt[i].exp_ena));
            chk($sformatf("v%0d_wen_cycles", i), 64'(wen_n), 64'(vt[i].exp_wen));
            chk($sformatf("v%0d_mask", i), 64'(mask), 64'(vt[i].exp_mask));
            chk($sformatf("v%0d_wdata", i), wd, vt[i].exp_wd);
        end

        // Back-pressure: response held while WBU stalls; queued request waits for the handshake
        sel = 1; rd_force = 1'b1; rd_val = 64'h0123_4567_89AB_CDEF;
        req_wen = 1'b0; req_funct3 = 3'd3; req_addr = 64'h8000_0008; req_wdata = '0;
        resp_ready[1] = 1'b0; req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        cyc = 0;
        while (!resp_valid[1] && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("stall_resp_seen", 64'(resp_valid[1]), 64'd1);
        stall_d = 64'h0123_4567_89AB_CDEF;
        req_funct3 = 3'd0; req_addr = 64'h8000_0010; req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_valid", c), 64'(resp_valid[1]), 64'd1);
            chk($sformatf("stall%0d_data", c), resp_data[1], stall_d);
            chk($sformatf("stall%0d_req_ready", c), 64'(req_ready[1]), 64'd0);
            chk($sformatf("stall%0d_mem_ena", c), 64'(mem_ena[1]), 64'd0);
            @(posedge clk); #1;
        end
        resp_ready[1] = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_req_ready", 64'(req_ready[1]), 64'd1);
        chk("post_hs_resp_valid", 64'(resp_valid[1]), 64'd0);
        chk("post_hs_no_bypass", 64'(mem_ena[1]), 64'd0);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("next_req_accepted", 64'(mem_ena[1]), 64'd1);
        cyc = 0;
        while (!resp_valid[1] && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("next_req_data", resp_data[1], 64'hFFFF_FFFF_FFFF_FFEF);
        @(posedge clk); #1;

        // Reset during the 2nd ACCESS cycle of a LATENCY=4 store
        rd_force = 1'b0;
        reinit();
        sel = 2; wen_seen = 0;
        req_wen = 1'b1; req_funct3 = 3'd3; req_addr = 64'h8000_0010; req_wdata = 64'hFFEE_DDCC_BBAA_9988;
        req_valid[2] = 1'b1;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        chk("rstmid_ena_c1", 64'(mem_ena[2]), 64'd1);
        if (mem_wen[2]) wen_seen++;
        @(posedge clk); #1;
        chk("rstmid_ena_c2", 64'(mem_ena[2]), 64'd1);
        if (mem_wen[2]) wen_seen++;
        rst_n = 1'b0;
        #1;
        chk_reset("rstmid", 2);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (mem_wen[2]) wen_seen++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (mem_wen[2]) wen_seen++;
        end
        chk("rstmid_wen_never", 64'(wen_seen), 64'd0);
        chk("rstmid_ready_after", 64'(req_ready[2]), 64'd1);
        bad = 0;
        for (int i = 16; i < 24; i++) if (pmem[i] !== rmem[i]) bad++;
        chk("rstmid_mem_untouched", 64'(bad), 64'd0);

        // Random traffic against the byte-level reference
        reinit();
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 60; n++) begin
                logic rw;
                logic [2:0] f3;
                logic [63:0] a, wdat;
                int off, sz;
                rw = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                sz = 1 << f3[1:0];
                off = $urandom_range(0, 127);
                if ($urandom_range(0, 3) != 0) off = off & ~(sz - 1);
                a = 64'h8000_0000 + 64'(off);
                wdat = {$urandom, $urandom};
                run_req(k, rw, f3, a, wdat, d, e, lat, ena_n, wen_n, mask, wd);
                if (ref_err(rw, f3, a)) begin
                    chk($sformatf("r%0d_%0d_err", k, n), 64'(e), 64'd1);
                    chk($sformatf("r%0d_%0d_data", k, n), d, 64'd0);
                    chk($sformatf("r%0d_%0d_latency", k, n), 64'(lat), 64'd1);
                    chk($sformatf("r%0d_%0d_ena", k, n), 64'(ena_n), 64'd0);
                end else begin
                    if (rw) begin
                        for (int i = 0; i < sz; i++) rmem[int'(a[6:0]) + i] = wdat[8*i +: 8];
                        exp = 64'd0;
                    end else begin
                        exp = ref_load(f3, a);
                    end
                    chk($sformatf("r%0d_%0d_err", k, n), 64'(e), 64'd0);
                    chk($sformatf("r%0d_%0d_data", k, n), d, exp);
                    chk($sformatf("r%0d_%0d_latency", k, n), 64'(lat), 64'(lat_of(k) + 1));
                    chk($sformatf("r%0d_%0d_ena", k, n), 64'(ena_n), 64'(lat_of(k)));
                    chk($sformatf("r%0d_%0d_wen", k, n), 64'(wen_n), 64'(rw ? 1 : 0));
                end
            end
        end
        bad = 0;
        for (int i = 0; i < 128; i++) if (pmem[i] !== rmem[i]) bad++;
        chk("final_mem_image", 64'(bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
